// File: rtl/gpio_arith_pkg.sv
// Shared definitions for the GPIO arithmetic core: register offsets,
// FSM state encoding and STAT bit positions.
package gpio_arith_pkg;

    // Register offsets relative to the block base address
    localparam logic [15:0] OFF_A1   = 16'd0;
    localparam logic [15:0] OFF_A2   = 16'd8;
    localparam logic [15:0] OFF_W    = 16'd16;
    localparam logic [15:0] OFF_L    = 16'd24;
    localparam logic [15:0] OFF_CTRL = 16'd32;
    localparam logic [15:0] OFF_GPIN = 16'd40;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_MULT  = 3'd2;
    localparam logic [2:0] ST_COUNT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // STAT bit positions
    localparam int STAT_VALID = 0;
    localparam int STAT_READY = 1;
    localparam int STAT_REJ   = 2;

    typedef struct packed {
        logic rej;
        logic ready;
        logic valid;
    } stat_t;

    // Build the 32-bit STAT read word from its flags
    function automatic logic [31:0] stat_word(input stat_t s);
        logic [31:0] w;
        w = 32'd0;
        w[STAT_VALID] = s.valid;
        w[STAT_READY] = s.ready;
        w[STAT_REJ]   = s.rej;
        return w;
    endfunction

endpackage

// File: rtl/gpio_serial_mul.sv
// Bit-serial shift-add multiplier. A start pulse snapshots the operands and
// clears the accumulator; one multiplier bit is consumed per cycle after that.
// o_done is high during the cycle whose closing edge performs the last step,
// so o_product holds the full result from the following cycle onward.
module gpio_serial_mul
    import gpio_arith_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic                  o_done,
    output logic [2*DATA_W-1:0]   o_product
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;

    // Load operands on start, then add-and-shift once per cycle while busy
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= CW'(DATA_W);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done    = r_busy && (r_cnt == CW'(1));
    assign o_product = r_acc;

endmodule

// File: rtl/gpio_arith_core.sv
// GPIO arithmetic core: register-mapped operands A1/A2, a bit-serial multiply
// followed by a bit-serial popcount of the truncated product, an operation
// counter driven onto gpio_out, and a GPIO input sample register.
//
// Bus handshake: srd/swr are single-cycle strobes sampled on the rising edge;
// there is no back-pressure. A write lands on that edge, and a read loads
// sdata_out on that edge with the contents as they were before any write in
// the same cycle. sdata_out holds its value between reads.
module gpio_arith_core
    import gpio_arith_pkg::*;
#(
    parameter int          DATA_W = 24,
    parameter int          RES_W  = 32,
    parameter int          CNT_W  = 16,
    parameter logic [15:0] BASE   = 16'h0380
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_in_s_insp,
    output logic [2:0]  o_dbg_state
);

    localparam int LW = $clog2(RES_W + 1);
    localparam int BW = $clog2(RES_W + 1);

    logic [2:0]          r_state;
    logic [DATA_W-1:0]   r_a1;
    logic [DATA_W-1:0]   r_a2;
    logic [RES_W-1:0]    r_w;
    logic [LW-1:0]       r_l;
    logic                r_valid;
    logic                r_rej;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_sdata_out;
    logic [31:0]         r_gpin;
    logic                r_run;
    logic [RES_W-1:0]    r_sh;
    logic [LW-1:0]       r_pc;
    logic [BW-1:0]       r_bit;

    logic                w_hit_a1;
    logic                w_hit_a2;
    logic                w_hit_w;
    logic                w_hit_l;
    logic                w_hit_ctrl;
    logic                w_hit_gpin;
    logic                w_ready;
    logic                w_start_req;
    logic                w_start;
    logic                w_reject;
    logic                w_stat_rd;
    logic                w_mul_done;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_hi_zero;
    logic [RES_W-1:0]    w_src;
    logic [31:0]         w_rd_data;
    logic                w_unused_ok;
    stat_t               w_stat;

    assign w_hit_a1   = (saddress == BASE + OFF_A1);
    assign w_hit_a2   = (saddress == BASE + OFF_A2);
    assign w_hit_w    = (saddress == BASE + OFF_W);
    assign w_hit_l    = (saddress == BASE + OFF_L);
    assign w_hit_ctrl = (saddress == BASE + OFF_CTRL);
    assign w_hit_gpin = (saddress == BASE + OFF_GPIN);

    assign w_ready     = (r_state == ST_IDLE);
    assign w_start_req = swr && w_hit_ctrl && sdata_in[0];
    // r_run blocks a start in the first cycle after reset release
    assign w_start     = w_start_req && w_ready && r_run;
    assign w_reject    = w_start_req && !w_ready;
    assign w_stat_rd   = srd && w_hit_ctrl;

    // Product bits above the result width must be zero for W to be exact
    assign w_hi_zero = ((w_prod >> RES_W) == {(2*DATA_W){1'b0}});

    // First popcount cycle reads the product directly, later ones the shifter
    assign w_src = (r_bit == BW'(0)) ? w_prod[RES_W-1:0] : r_sh;

    assign w_stat.rej   = r_rej;
    assign w_stat.ready = w_ready;
    assign w_stat.valid = r_valid;

    // Operand bits above DATA_W and the CTRL upper bits are never stored
    assign w_unused_ok = &{1'b0, sdata_in};

    gpio_serial_mul #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (clk),
        .n_reset   (n_reset),
        .i_start   (r_state == ST_LOAD),
        .i_a       (r_a1),
        .i_b       (r_a2),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );

    // Sequencer: IDLE -> LOAD -> MULT -> COUNT -> DONE -> IDLE
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_start) r_state <= ST_LOAD;
                ST_LOAD:  r_state <= ST_MULT;
                ST_MULT:  if (w_mul_done) r_state <= ST_COUNT;
                ST_COUNT: if (r_bit == BW'(RES_W - 1)) r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Popcount: clear in LOAD, shift one result bit out per COUNT cycle
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sh  <= '0;
            r_pc  <= '0;
            r_bit <= '0;
        end else if (r_state == ST_LOAD) begin
            r_sh  <= '0;
            r_pc  <= '0;
            r_bit <= '0;
        end else if (r_state == ST_COUNT) begin
            r_pc  <= r_pc + LW'(w_src[0]);
            r_sh  <= w_src >> 1;
            r_bit <= r_bit + BW'(1);
        end
    end

    // Publish results and bump the operation counter only in DONE
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_w     <= '0;
            r_l     <= '0;
            r_valid <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == ST_DONE) begin
            r_w     <= w_prod[RES_W-1:0];
            r_l     <= r_pc;
            r_valid <= w_hi_zero;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Operand registers accept writes only while idle
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_a1 <= '0;
            r_a2 <= '0;
        end else if (swr && w_ready) begin
            if (w_hit_a1) r_a1 <= sdata_in[DATA_W-1:0];
            if (w_hit_a2) r_a2 <= sdata_in[DATA_W-1:0];
        end
    end

    // Sticky reject flag: a new reject wins over a same-cycle STAT read clear
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rej <= 1'b0;
        end else if (w_reject) begin
            r_rej <= 1'b1;
        end else if (w_stat_rd) begin
            r_rej <= 1'b0;
        end
    end

    // Start gate opens on the first clock edge after reset release
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Read data mux; unmapped addresses return zero
    always_comb begin
        w_rd_data = 32'd0;
        if (w_hit_a1)   w_rd_data = 32'(r_a1);
        if (w_hit_a2)   w_rd_data = 32'(r_a2);
        if (w_hit_w)    w_rd_data = 32'(r_w);
        if (w_hit_l)    w_rd_data = 32'(r_l);
        if (w_hit_ctrl) w_rd_data = stat_word(w_stat);
        if (w_hit_gpin) w_rd_data = r_gpin;
    end

    // Registered read port, updated only on a read strobe
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sdata_out <= 32'd0;
        end else if (srd) begin
            r_sdata_out <= w_rd_data;
        end
    end

    // GPIO input sample register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_gpin <= 32'd0;
        end else if (gpio_latch) begin
            r_gpin <= gpio_in;
        end
    end

    assign sdata_out      = r_sdata_out;
    assign gpio_out       = 32'(r_cnt);
    assign gpio_in_s_insp = r_gpin;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_gpio_arith_core.sv
// Directed bench for gpio_arith_core (CNT_W reduced to 4 so the counter
// wrap is reachable in a short run).
module tb_gpio_arith_core;

    localparam logic [15:0] A_A1   = 16'h0380;
    localparam logic [15:0] A_A2   = 16'h0388;
    localparam logic [15:0] A_W    = 16'h0390;
    localparam logic [15:0] A_L    = 16'h0398;
    localparam logic [15:0] A_CTRL = 16'h03A0;
    localparam logic [15:0] A_GPIN = 16'h03A8;
    localparam logic [2:0]  S_IDLE = 3'd0;
    localparam logic [2:0]  S_MULT = 3'd2;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] saddress = 16'd0;
    logic        srd = 1'b0;
    logic        swr = 1'b0;
    logic [31:0] sdata_in = 32'd0;
    logic [31:0] sdata_out;
    logic [31:0] gpio_in = 32'd0;
    logic        gpio_latch = 1'b0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in_s_insp;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    gpio_arith_core #(
        .DATA_W (24),
        .RES_W  (32),
        .CNT_W  (4),
        .BASE   (16'h0380)
    ) u_dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_in       (sdata_in),
        .sdata_out      (sdata_out),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out),
        .gpio_in_s_insp (gpio_in_s_insp),
        .o_dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        saddress = addr;
        sdata_in = data;
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [31:0] data);
        @(negedge clk);
        saddress = addr;
        srd = 1'b1;
        @(negedge clk);
        srd = 1'b0;
        data = sdata_out;
    endtask

    task automatic do_rw(input logic [15:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        saddress = addr;
        sdata_in = wdata;
        srd = 1'b1;
        swr = 1'b1;
        @(negedge clk);
        srd = 1'b0;
        swr = 1'b0;
        rdata = sdata_out;
    endtask

    // Bounded wait for the sequencer to return to idle; cyc counts edges
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (dbg_state !== S_IDLE && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_idle", 32'(dbg_state), 32'(S_IDLE));
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int cyc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sdata_out", sdata_out, 32'd0);
        check("rst_gpio_out", gpio_out, 32'd0);
        check("rst_insp", gpio_in_s_insp, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        do_read(A_CTRL, rd); check("rst_stat", rd, 32'h3);
        do_read(A_W, rd);    check("rst_w", rd, 32'd0);

        // 3 * 5
        do_write(A_A1, 32'd3);
        do_write(A_A2, 32'd5);
        do_write(A_CTRL, 32'd1);
        wait_idle(cyc);
        check("latency", 32'(cyc), 32'd58);
        do_read(A_CTRL, rd); check("op1_stat", rd, 32'h3);
        do_read(A_W, rd);    check("op1_w", rd, 32'd15);
        do_read(A_L, rd);    check("op1_l", rd, 32'd4);
        check("op1_gpio_out", gpio_out, 32'd1);
        do_read(A_A1, rd);   check("op1_a1", rd, 32'd3);

        // FFFFFF * FFFFFF with a rejected restart, busy reads and busy write
        do_write(A_A1, 32'hFFFF_FFFF);
        do_write(A_A2, 32'h00FF_FFFF);
        do_write(A_CTRL, 32'd1);
        repeat (8) @(negedge clk);
        do_write(A_CTRL, 32'd1);
        do_read(A_W, rd);    check("busy_w_old", rd, 32'd15);
        do_write(A_A1, 32'd7);
        do_read(A_CTRL, rd); check("busy_stat_rej", rd, 32'h5);
        do_read(A_CTRL, rd); check("busy_stat_clr", rd, 32'h1);
        check("busy_gpio_out", gpio_out, 32'd1);
        wait_idle(cyc);
        do_read(A_W, rd);    check("op2_w", rd, 32'hFE00_0001);
        do_read(A_L, rd);    check("op2_l", rd, 32'd8);
        do_read(A_CTRL, rd); check("op2_stat", rd, 32'h2);
        check("op2_gpio_out", gpio_out, 32'd2);
        do_read(A_A1, rd);   check("op2_a1_kept", rd, 32'h00FF_FFFF);

        // GPIO sample
        @(negedge clk);
        gpio_in = 32'hA5A5_0F0F;
        gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0;
        gpio_in = 32'h1234_5678;
        @(negedge clk);
        check("gpio_insp", gpio_in_s_insp, 32'hA5A5_0F0F);
        do_read(A_GPIN, rd); check("gpio_gpin", rd, 32'hA5A5_0F0F);

        // Reset at MULT cycle 20
        do_write(A_CTRL, 32'd1);
        repeat (21) @(negedge clk);
        check("abort_in_mult", 32'(dbg_state), 32'(S_MULT));
        n_reset = 1'b0;
        #1;
        check("abort_sdata_out", sdata_out, 32'd0);
        check("abort_gpio_out", gpio_out, 32'd0);
        check("abort_insp", gpio_in_s_insp, 32'd0);
        check("abort_state", 32'(dbg_state), 32'(S_IDLE));
        repeat (3) @(negedge clk);
        // Start attempted in the release cycle must be ignored
        n_reset = 1'b1;
        saddress = A_CTRL;
        sdata_in = 32'd1;
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        check("release_no_start", 32'(dbg_state), 32'(S_IDLE));
        repeat (60) @(negedge clk);
        check("abort_no_incr", gpio_out, 32'd0);
        do_read(A_W, rd);    check("abort_w", rd, 32'd0);
        do_read(A_L, rd);    check("abort_l", rd, 32'd0);
        do_read(A_CTRL, rd); check("abort_stat", rd, 32'h3);
        do_read(A_A1, rd);   check("abort_a1", rd, 32'd0);

        // Simultaneous read and write returns pre-write contents
        do_write(A_A1, 32'd3);
        do_write(A_A2, 32'd5);
        do_rw(A_A1, 32'd9, rd); check("rw_old", rd, 32'd3);
        do_read(A_A1, rd);      check("rw_new", rd, 32'd9);

        // 16 operations wrap a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            do_write(A_CTRL, 32'd1);
            wait_idle(cyc);
            if (i == 14) check("wrap_15", gpio_out, 32'd15);
        end
        check("wrap_0", gpio_out, 32'd0);
        do_read(A_W, rd);       check("op9x5_w", rd, 32'd45);
        do_read(A_L, rd);       check("op9x5_l", rd, 32'd4);
        do_read(16'h0384, rd);  check("unmapped_4", rd, 32'd0);
        do_read(A_L, rd);       check("op9x5_l_again", rd, 32'd4);
        do_read(16'h03B0, rd);  check("unmapped_48", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_arith_core.md
GPIO_ARITH_CORE -- requirements
Module: gpio_arith_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, operand width (8..32).
REQ-002 The block SHALL have parameter RES_W, default 32, width of result register W (<= 2*DATA_W, <= 32).
REQ-003 The block SHALL have parameter CNT_W, default 16, operation counter width (<= 32).
REQ-004 The block SHALL have parameter BASE, default 16'h0380, register base address.
REQ-005 The block SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 The block SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port saddress  input  16  register address.
REQ-008 The block SHALL have port srd  input  1  read strobe, one clk cycle, synchronous.
REQ-009 The block SHALL have port swr  input  1  write strobe, one clk cycle, synchronous.
REQ-010 The block SHALL have port sdata_in  input  32  write data.
REQ-011 The block SHALL have port sdata_out  output  32  registered read data.
REQ-012 The block SHALL have port gpio_in  input  32  GPIO input.
REQ-013 The block SHALL have port gpio_latch  input  1  GPIO sample strobe.
REQ-014 The block SHALL have port gpio_out  output  32  zero-extended operation counter.
REQ-015 The block SHALL have port gpio_in_s_insp  output  32  latched GPIO value.

Function
REQ-016 Register map SHALL be: A1 BASE+0 (RW), A2 BASE+8 (RW), W BASE+16 (RO), L BASE+24 (RO), CTRL/STAT BASE+32 (RW), GPIN BASE+40 (RO).
REQ-017 Writes to A1/A2 SHALL store sdata_in[DATA_W-1:0] only when ready=1; ignored otherwise.
REQ-018 STAT SHALL read {29'b0, rej, ready, valid}; ready=1 when idle, valid=1 when product high bits [2*DATA_W-1:RES_W] are all zero.
REQ-019 A write to CTRL with sdata_in[0]=1 while ready=1 SHALL start an operation; while ready=0 it SHALL be ignored and set sticky rej.
REQ-020 A read of STAT SHALL clear rej in the same cycle it is reported (rej returned as 1, then 0).
REQ-021 FSM SHALL be IDLE -> LOAD (1 cycle) -> MULT (DATA_W cycles) -> COUNT (RES_W cycles) -> DONE (1 cycle) -> IDLE.
REQ-022 LOAD SHALL clear accumulator and popcount, snapshot A1/A2, and drive ready=0.
REQ-023 MULT SHALL perform shift-add, one multiplier bit per cycle, into a 2*DATA_W accumulator.
REQ-024 COUNT SHALL shift out W one bit per cycle and increment L for each 1.
REQ-025 DONE SHALL update W, L, and valid; increment the counter (wrapping 2^CNT_W-1 -> 0); and set ready=1.
REQ-026 Latency SHALL be DATA_W+RES_W+2 cycles from the start-strobe edge to ready=1.
REQ-027 W, L, and valid SHALL hold previous results until DONE, so reads during busy return the old values.
REQ-028 sdata_out SHALL update one cycle after srd, hold its value otherwise, and be 0 for unmapped addresses.
REQ-029 gpio_in_s_insp SHALL capture gpio_in on a clk cycle where gpio_latch=1.
REQ-030 When srd and swr arrive together, both SHALL be serviced; the read returns pre-write contents.

Reset
REQ-031 n_reset low SHALL immediately force: FSM IDLE; A1, A2, W, L, counter, sdata_out, and gpio_in_s_insp to 0; ready=1; valid=1; rej=0.
REQ-032 Reset mid-operation SHALL abort with no counter increment and no W/L update.
REQ-033 Reset deassertion SHALL take effect on the next clk edge; no start is accepted in the deassertion cycle.

Structure
REQ-034 Register offsets, FSM state encoding, and STAT bit positions SHALL reside in shared package gpio_arith_pkg.
REQ-035 The bit-serial shift-add multiplier SHALL be sub-module gpio_serial_mul (start, done, operands, product).

Verification
REQ-036 Write A1=3, A2=5, start -> after 58 cycles STAT=3'b011, W=15, L=4, gpio_out=1.
REQ-037 A1=24'hFFFFFF, A2=24'hFFFFFF, start -> W=32'hFE000001, L=8, valid=0.
REQ-038 Start, then start again at cycle 10 -> second start ignored, STAT rej=1, next STAT read rej=0, gpio_out increments by 1 only.
REQ-039 Assert n_reset at cycle 20 of MULT -> all outputs 0, STAT=3'b011, gpio_out unchanged at 0.
REQ-040 gpio_in=32'hA5A5_0F0F, pulse gpio_latch, change gpio_in -> gpio_in_s_insp and GPIN read = 32'hA5A5_0F0F.
REQ-041 With CNT_W=4, run 16 operations -> gpio_out wraps to 0; a read at BASE+4 returns 0.
